alu_bist_seq: RTL and testbench

- Synthesizable, self-checking ALU stimulus sequencer. Parametrised hardware successor to the random-stimulus, opcode-sweeping ALU bench.
- Drives the ALU operand/opcode inputs from two LFSRs and sweeps an opcode range, issuing a fixed number of vectors per opcode.
- Compresses every ALU result, carry and flag set into a MISR signature, then reports pass/fail against a golden value.
- Sits beside the ALU for built-in self-test, or in front of a multi-cycle ALU through a valid/ready handshake.

---
 rtl/alu_bist_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_bist_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_seq.sv
// Built-in self-test sequencer for an ALU: LFSR operands, opcode sweep,
// MISR compression of every result, pass/fail against a golden signature.
module alu_bist_seq #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      OP_W        = 7,
    parameter int unsigned      FLAG_W      = 5,
    parameter int unsigned      OP_FIRST    = 3,
    parameter int unsigned      OP_LAST     = 16,
    parameter int unsigned      VECS_PER_OP = 4,
    parameter logic [WIDTH-1:0] SEED_A      = 32'h00000001,
    parameter logic [WIDTH-1:0] SEED_B      = 32'h00000003,
    parameter logic [WIDTH-1:0] POLY        = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] GOLDEN_SIG  = 32'h0,
    parameter int unsigned      TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [WIDTH-1:0]  op_a,
    output logic [WIDTH-1:0]  op_b,
    output logic [OP_W-1:0]   opcode,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic              res_valid,
    input  logic [WIDTH-1:0]  res_out,
    input  logic              res_carry,
    input  logic [FLAG_W-1:0] res_flags,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [WIDTH-1:0]  signature,
    output logic [15:0]       vec_count
);

    localparam int unsigned     CW        = $clog2(TIMEOUT + 1);
    localparam int unsigned     PW        = (VECS_PER_OP > 1) ? $clog2(VECS_PER_OP) : 1;
    localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0]   VEC_LAST  = PW'(VECS_PER_OP - 1);
    localparam logic [OP_W-1:0] OPC_FIRST = OP_W'(OP_FIRST);
    localparam logic [OP_W-1:0] OPC_LAST  = OP_W'(OP_LAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic [CW-1:0]    wait_cnt;
    logic [PW-1:0]    vec_idx;
    logic             handshake;
    logic             wait_expired;
    logic             more_vecs;
    logic             last_op;

    // Shared shift/feedback step used by both operand LFSRs and the MISR.
    function automatic logic [WIDTH-1:0] shift_fb(input logic [WIDTH-1:0] cur);
        return {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? POLY : '0);
    endfunction

    always_comb begin
        handshake    = op_valid && op_ready;
        wait_expired = (wait_cnt == WAIT_LAST);
        more_vecs    = (vec_idx < VEC_LAST);
        last_op      = (opcode == OPC_LAST);
        state_nx     = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ISSUE;
            S_ISSUE: if (handshake) state_nx = S_WAIT;
            S_WAIT: begin
                if (res_valid)         state_nx = S_NEXT;
                else if (wait_expired) state_nx = S_DONE;
            end
            S_NEXT: begin
                if (!more_vecs && last_op) state_nx = S_DONE;
                else                       state_nx = S_ISSUE;
            end
            S_DONE:  if (start) state_nx = S_ISSUE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            opcode    <= '0;
            op_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            signature <= '0;
            vec_count <= '0;
            lfsr_a    <= SEED_A;
            lfsr_b    <= SEED_B;
            wait_cnt  <= '0;
            vec_idx   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lfsr_a    <= SEED_A;
                        lfsr_b    <= SEED_B;
                        op_a      <= SEED_A;
                        op_b      <= SEED_B;
                        opcode    <= OPC_FIRST;
                        op_valid  <= 1'b1;
                        vec_idx   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        signature <= '0;
                        vec_count <= '0;
                    end
                end
                S_ISSUE: begin
                    if (handshake) begin
                        lfsr_a   <= shift_fb(lfsr_a);
                        lfsr_b   <= shift_fb(lfsr_b);
                        op_valid <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        signature <= shift_fb(signature) ^ res_out
                                     ^ WIDTH'({res_carry, res_flags});
                        vec_count <= vec_count + 16'd1;
                    end else if (wait_expired) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_NEXT: begin
                    // Operands are reloaded here from the already-advanced LFSRs.
                    if (more_vecs) begin
                        vec_idx  <= vec_idx + PW'(1);
                        op_a     <= lfsr_a;
                        op_b     <= lfsr_b;
                        op_valid <= 1'b1;
                    end else if (last_op) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (signature == GOLDEN_SIG);
                    end else begin
                        opcode   <= opcode + OP_W'(1);
                        vec_idx  <= '0;
                        op_a     <= lfsr_a;
                        op_b     <= lfsr_b;
                        op_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_seq.sv
// Self-checking bench for alu_bist_seq: an ALU responder driven from
// $urandom, checked against an arithmetic model of the issued sequence.
module tb_alu_bist_seq;

    localparam int unsigned OPF  = 3;
    localparam int unsigned OPL  = 5;
    localparam int unsigned VPO  = 2;
    localparam int unsigned TMO  = 8;
    localparam int unsigned NV   = (OPL - OPF + 1) * VPO;
    localparam logic [31:0] SA   = 32'h00000001;
    localparam logic [31:0] SB   = 32'h00000003;
    localparam logic [31:0] POLYV = 32'h04C11DB7;
    localparam logic [31:0] GOLD = 32'h0000003F;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [6:0]  opcode;
    logic        op_valid;
    logic        op_ready;
    logic        res_valid;
    logic [31:0] res_out;
    logic        res_carry;
    logic [4:0]  res_flags;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] signature;
    logic [15:0] vec_count;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    logic [31:0] exp_a [NV];
    logic [31:0] exp_b [NV];
    int unsigned exp_op[NV];

    alu_bist_seq #(
        .OP_FIRST   (OPF),
        .OP_LAST    (OPL),
        .VECS_PER_OP(VPO),
        .GOLDEN_SIG (GOLD),
        .TIMEOUT    (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .opcode   (opcode),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .res_valid(res_valid),
        .res_out  (res_out),
        .res_carry(res_carry),
        .res_flags(res_flags),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .timeout  (timeout),
        .signature(signature),
        .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] x);
        return (x << 1) ^ (x[31] ? POLYV : 32'h0);
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] r,
                                         input logic c, input logic [4:0] f);
        return step(s) ^ r ^ {26'h0, c, f};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_op_a"},     op_a, 32'h0);
        check({tag, "_op_b"},     op_b, 32'h0);
        check({tag, "_opcode"},   32'(opcode), 32'h0);
        check({tag, "_op_valid"}, 32'(op_valid), 32'h0);
        check({tag, "_busy"},     32'(busy), 32'h0);
        check({tag, "_done"},     32'(done), 32'h0);
        check({tag, "_pass"},     32'(pass), 32'h0);
        check({tag, "_timeout"},  32'(timeout), 32'h0);
        check({tag, "_sig"},      signature, 32'h0);
        check({tag, "_vec_count"}, 32'(vec_count), 32'h0);
    endtask

    // One full run from IDLE/DONE; optionally stall, randomise, starve or abort.
    task automatic run(input int stall, input bit rnd, input bit no_resp, input bit abort);
        logic [31:0] sig;
        logic [31:0] r;
        logic        c;
        logic [4:0]  f;
        int          k;
        int          dly;
        sig = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'h1);
        check("start_done", 32'(done), 32'h0);
        check("start_timeout", 32'(timeout), 32'h0);
        check("start_sig", signature, 32'h0);
        check("start_vec_count", 32'(vec_count), 32'h0);
        for (int v = 0; v < int'(NV); v++) begin
            k = 0;
            while (!op_valid && k < 8) begin
                @(negedge clk);
                k++;
            end
            check("op_valid", 32'(op_valid), 32'h1);
            check("op_a", op_a, exp_a[v]);
            check("op_b", op_b, exp_b[v]);
            check("opcode", 32'(opcode), exp_op[v]);
            for (int s = 0; s < stall && v == 0; s++) begin
                op_ready = 1'b0;
                start    = s[0];
                @(negedge clk);
                check("stall_valid", 32'(op_valid), 32'h1);
                check("stall_op_a", op_a, exp_a[v]);
                check("stall_op_b", op_b, exp_b[v]);
                check("stall_opcode", 32'(opcode), exp_op[v]);
            end
            start     = 1'b0;
            op_ready  = 1'b1;
            res_valid = rnd ? 1'($urandom) : 1'b0;
            res_out   = $urandom;
            res_carry = 1'($urandom);
            res_flags = 5'($urandom);
            @(negedge clk);
            op_ready  = 1'b0;
            res_valid = 1'b0;
            check("hs_valid_low", 32'(op_valid), 32'h0);
            if (abort) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_zero("abort");
                return;
            end
            if (no_resp) begin
                k = 0;
                while (!done && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                check("wait_cycles", 32'(k), TMO);
                check("to_done", 32'(done), 32'h1);
                check("to_timeout", 32'(timeout), 32'h1);
                check("to_pass", 32'(pass), 32'h0);
                check("to_busy", 32'(busy), 32'h0);
                check("to_vec_count", 32'(vec_count), 32'h0);
                return;
            end
            dly = rnd ? int'($urandom_range(0, 3)) : 0;
            repeat (dly) @(negedge clk);
            r = rnd ? $urandom : 32'h1;
            c = rnd ? 1'($urandom) : 1'b0;
            f = rnd ? 5'($urandom) : 5'h0;
            res_valid = 1'b1;
            res_out   = r;
            res_carry = c;
            res_flags = f;
            sig = misr(sig, r, c, f);
            @(negedge clk);
            res_valid = rnd ? 1'($urandom) : 1'b0;
            res_out   = $urandom;
            check("sig", signature, sig);
            check("vec_count", 32'(vec_count), 32'(v + 1));
        end
        res_valid = 1'b0;
        k = 0;
        while (!done && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("end_done", 32'(done), 32'h1);
        check("end_busy", 32'(busy), 32'h0);
        check("end_timeout", 32'(timeout), 32'h0);
        check("end_pass", 32'(pass), 32'(sig == GOLD));
        check("end_sig", signature, sig);
        check("end_vec_count", 32'(vec_count), NV);
        repeat (3) begin
            @(negedge clk);
            check("idle_valid", 32'(op_valid), 32'h0);
            check("idle_opcode", 32'(opcode), OPL);
            check("idle_done", 32'(done), 32'h1);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        a = SA;
        b = SB;
        for (int v = 0; v < int'(NV); v++) begin
            exp_a[v]  = a;
            exp_b[v]  = b;
            exp_op[v] = OPF + v / VPO;
            a = step(a);
            b = step(b);
        end

        reset     = 1'b1;
        start     = 1'b1;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        res_out   = '0;
        res_carry = 1'b0;
        res_flags = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_zero("reset");
        @(negedge clk);
        check_zero("idle");

        run(0, 1'b0, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0, 1'b0);
        repeat (3) run(0, 1'b1, 1'b0, 1'b0);
        run(0, 1'b0, 1'b1, 1'b0);
        run(0, 1'b0, 1'b0, 1'b1);
        run(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
